// File: rtl/simd32_wb.sv
// SIMD32 writeback stage: merges load/store and ALU results onto the scalar
// and vector register-file write ports, splitting 64-bit results into two beats.

package common_pkg;
    localparam int THREADS_PER_WAVEFRONT = 32;
    localparam int SGPR_ADDR_WIDTH       = 7;
    localparam int VGPR_ADDR_WIDTH       = 8;
    localparam int SGPR_DATA_WIDTH       = 32;
    localparam int VGPR_DATA_WIDTH       = 32;
    localparam int WAVEFRONT_WIDTH       = 4;
endpackage

module simd32_wb
    import common_pkg::*;
#(
    parameter int LS_FIFO_DEPTH = 4
) (
    input  logic                                                 clk,
    input  logic                                                 reset,
    input  logic [SGPR_ADDR_WIDTH-1:0]                           ls_wb_s_dest_reg,
    input  logic [2*SGPR_DATA_WIDTH-1:0]                         ls_wb_s_val,
    input  logic [1:0]                                           ls_wb_s_strb,
    input  logic                                                 ls_wb_s_we,
    input  logic [VGPR_ADDR_WIDTH-1:0]                           ls_wb_v_dest_reg,
    input  logic [THREADS_PER_WAVEFRONT*2*VGPR_DATA_WIDTH-1:0]   ls_wb_v_val,
    input  logic [1:0]                                           ls_wb_v_strb,
    input  logic [THREADS_PER_WAVEFRONT-1:0]                     ls_wb_v_we,
    input  logic [WAVEFRONT_WIDTH-1:0]                           ls_wb_wavefront_num,
    input  logic                                                 alu_wb_valid,
    output logic                                                 alu_wb_ready,
    input  logic [SGPR_ADDR_WIDTH-1:0]                           alu_wb_s_dest_reg,
    input  logic [2*SGPR_DATA_WIDTH-1:0]                         alu_wb_s_val,
    input  logic [1:0]                                           alu_wb_s_strb,
    input  logic                                                 alu_wb_s_we,
    input  logic [VGPR_ADDR_WIDTH-1:0]                           alu_wb_v_dest_reg,
    input  logic [THREADS_PER_WAVEFRONT*2*VGPR_DATA_WIDTH-1:0]   alu_wb_v_val,
    input  logic [1:0]                                           alu_wb_v_strb,
    input  logic [THREADS_PER_WAVEFRONT-1:0]                     alu_wb_v_we,
    input  logic [WAVEFRONT_WIDTH-1:0]                           alu_wb_wavefront_num,
    output logic                                                 sgpr_we,
    output logic [SGPR_ADDR_WIDTH-1:0]                           sgpr_waddr,
    output logic [SGPR_DATA_WIDTH-1:0]                           sgpr_wdata,
    output logic [WAVEFRONT_WIDTH-1:0]                           sgpr_wf,
    output logic [THREADS_PER_WAVEFRONT-1:0]                     vgpr_we,
    output logic [VGPR_ADDR_WIDTH-1:0]                           vgpr_waddr,
    output logic [THREADS_PER_WAVEFRONT*VGPR_DATA_WIDTH-1:0]     vgpr_wdata,
    output logic [WAVEFRONT_WIDTH-1:0]                           vgpr_wf,
    output logic [$clog2(LS_FIFO_DEPTH):0]                       ls_fifo_count,
    output logic                                                 ls_fifo_overflow,
    output logic                                                 wb_busy
);

    localparam int T     = THREADS_PER_WAVEFRONT;
    localparam int SDW   = SGPR_DATA_WIDTH;
    localparam int VDW   = VGPR_DATA_WIDTH;
    localparam int PTR_W = $clog2(LS_FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [SGPR_ADDR_WIDTH-1:0] s_reg;
        logic [2*SDW-1:0]           s_val;
        logic [1:0]                 s_strb;
        logic                       s_we;
        logic [VGPR_ADDR_WIDTH-1:0] v_reg;
        logic [T*2*VDW-1:0]         v_val;
        logic [1:0]                 v_strb;
        logic [T-1:0]               v_we;
        logic [WAVEFRONT_WIDTH-1:0] wf;
    } entry_t;

    typedef enum logic {
        WB_IDLE = 1'b0,
        WB_HI   = 1'b1
    } state_t;

    // A beat is live when either its scalar or its vector half writes something.
    function automatic logic beat_active(input entry_t e, input logic k);
        return (e.s_we & e.s_strb[k]) | ((|e.v_we) & e.v_strb[k]);
    endfunction

    state_t              state;
    state_t              next_state;
    entry_t              fifo_mem [LS_FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    entry_t              held_entry;

    entry_t              ls_entry;
    entry_t              alu_entry;
    entry_t              sel_entry;
    entry_t              issue_entry;
    logic                ls_active;
    logic                fifo_empty;
    logic                fifo_full;
    logic                pop;
    logic                push;
    logic                drop;
    logic                alu_accept;
    logic                sel_valid;
    logic                issue_valid;
    logic                issue_hi;
    logic                latch;

    logic                       next_sgpr_we;
    logic [SGPR_ADDR_WIDTH-1:0] next_sgpr_waddr;
    logic [SDW-1:0]             next_sgpr_wdata;
    logic [T-1:0]               next_vgpr_we;
    logic [VGPR_ADDR_WIDTH-1:0] next_vgpr_waddr;
    logic [T*VDW-1:0]           next_vgpr_wdata;

    // Pack both result sources into the common entry format.
    always_comb begin
        ls_entry.s_reg   = ls_wb_s_dest_reg;
        ls_entry.s_val   = ls_wb_s_val;
        ls_entry.s_strb  = ls_wb_s_strb;
        ls_entry.s_we    = ls_wb_s_we;
        ls_entry.v_reg   = ls_wb_v_dest_reg;
        ls_entry.v_val   = ls_wb_v_val;
        ls_entry.v_strb  = ls_wb_v_strb;
        ls_entry.v_we    = ls_wb_v_we;
        ls_entry.wf      = ls_wb_wavefront_num;
        alu_entry.s_reg  = alu_wb_s_dest_reg;
        alu_entry.s_val  = alu_wb_s_val;
        alu_entry.s_strb = alu_wb_s_strb;
        alu_entry.s_we   = alu_wb_s_we;
        alu_entry.v_reg  = alu_wb_v_dest_reg;
        alu_entry.v_val  = alu_wb_v_val;
        alu_entry.v_strb = alu_wb_v_strb;
        alu_entry.v_we   = alu_wb_v_we;
        alu_entry.wf     = alu_wb_wavefront_num;
    end

    // FIFO status and arbitration: the FIFO head always wins over the ALU,
    // and a full FIFO still accepts a push when the head leaves the same cycle.
    always_comb begin
        fifo_empty   = (ls_fifo_count == '0);
        fifo_full    = (ls_fifo_count == CNT_W'(LS_FIFO_DEPTH));
        ls_active    = beat_active(ls_entry, 1'b0) | beat_active(ls_entry, 1'b1);
        alu_wb_ready = !reset && (state == WB_IDLE) && fifo_empty;
        pop          = (state == WB_IDLE) && !fifo_empty;
        alu_accept   = alu_wb_valid && alu_wb_ready;
        push         = ls_active && (!fifo_full || pop);
        drop         = ls_active && fifo_full && !pop;
        sel_valid    = pop || alu_accept;
        sel_entry    = pop ? fifo_mem[rd_ptr] : alu_entry;
        wb_busy      = !fifo_empty || (state == WB_HI);
    end

    // Beat selection: lowest active beat of a new entry, or the high beat of
    // the latched entry while in WB_HI.
    always_comb begin
        issue_valid = 1'b0;
        issue_hi    = 1'b0;
        issue_entry = held_entry;
        latch       = 1'b0;
        next_state  = state;
        case (state)
            WB_IDLE: begin
                if (sel_valid) begin
                    issue_entry = sel_entry;
                    if (beat_active(sel_entry, 1'b0)) begin
                        issue_valid = 1'b1;
                        if (beat_active(sel_entry, 1'b1)) begin
                            latch      = 1'b1;
                            next_state = WB_HI;
                        end
                    end else if (beat_active(sel_entry, 1'b1)) begin
                        issue_valid = 1'b1;
                        issue_hi    = 1'b1;
                    end
                end
            end
            WB_HI: begin
                issue_valid = 1'b1;
                issue_hi    = 1'b1;
                next_state  = WB_IDLE;
            end
            default: next_state = WB_IDLE;
        endcase
    end

    // Shape the chosen beat into register-file write values.
    always_comb begin
        next_sgpr_we    = issue_valid & issue_entry.s_we & issue_entry.s_strb[issue_hi];
        next_sgpr_waddr = issue_entry.s_reg + SGPR_ADDR_WIDTH'(issue_hi);
        next_sgpr_wdata = issue_hi ? issue_entry.s_val[SDW +: SDW] : issue_entry.s_val[0 +: SDW];
        next_vgpr_we    = issue_valid ? (issue_entry.v_we & {T{issue_entry.v_strb[issue_hi]}}) : '0;
        next_vgpr_waddr = issue_entry.v_reg + VGPR_ADDR_WIDTH'(issue_hi);
        next_vgpr_wdata = '0;
        for (int i = 0; i < T; i++) begin
            next_vgpr_wdata[i*VDW +: VDW] = issue_hi ? issue_entry.v_val[i*2*VDW + VDW +: VDW]
                                                     : issue_entry.v_val[i*2*VDW +: VDW];
        end
    end

    // FIFO storage and the latched double-beat entry carry no reset.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= ls_entry;
        if (latch) held_entry <= sel_entry;
    end

    // FSM, FIFO bookkeeping and registered write-port outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= WB_IDLE;
            wr_ptr           <= '0;
            rd_ptr           <= '0;
            ls_fifo_count    <= '0;
            ls_fifo_overflow <= 1'b0;
            sgpr_we          <= 1'b0;
            sgpr_waddr       <= '0;
            sgpr_wdata       <= '0;
            sgpr_wf          <= '0;
            vgpr_we          <= '0;
            vgpr_waddr       <= '0;
            vgpr_wdata       <= '0;
            vgpr_wf          <= '0;
        end else begin
            state <= next_state;
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   ls_fifo_count <= ls_fifo_count + CNT_W'(1);
                2'b01:   ls_fifo_count <= ls_fifo_count - CNT_W'(1);
                default: ls_fifo_count <= ls_fifo_count;
            endcase
            if (drop) ls_fifo_overflow <= 1'b1;
            sgpr_we <= next_sgpr_we;
            vgpr_we <= next_vgpr_we;
            if (issue_valid) begin
                sgpr_waddr <= next_sgpr_waddr;
                sgpr_wdata <= next_sgpr_wdata;
                sgpr_wf    <= issue_entry.wf;
                vgpr_waddr <= next_vgpr_waddr;
                vgpr_wdata <= next_vgpr_wdata;
                vgpr_wf    <= issue_entry.wf;
            end
        end
    end

endmodule

// File: tb/tb_simd32_wb.sv
// Self-checking bench for simd32_wb: scoreboard of expected register-file
// beats plus directed latency, priority, overflow, wrap and reset checks.
`timescale 1ns/1ps
module tb_simd32_wb;
    import common_pkg::*;

    localparam int T     = THREADS_PER_WAVEFRONT;
    localparam int SA    = SGPR_ADDR_WIDTH;
    localparam int VA    = VGPR_ADDR_WIDTH;
    localparam int WF    = WAVEFRONT_WIDTH;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [SA-1:0]   s_reg;
        logic [63:0]     s_val;
        logic [1:0]      s_strb;
        logic            s_we;
        logic [VA-1:0]   v_reg;
        logic [T*64-1:0] v_val;
        logic [1:0]      v_strb;
        logic [T-1:0]    v_we;
        logic [WF-1:0]   wf;
    } ent_t;

    typedef struct packed {
        logic            s_we;
        logic [SA-1:0]   s_addr;
        logic [31:0]     s_data;
        logic [T-1:0]    v_we;
        logic [VA-1:0]   v_addr;
        logic [T*32-1:0] v_data;
        logic [WF-1:0]   wf;
    } beat_t;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    ent_t            ls_e = '0;
    ent_t            alu_e = '0;
    logic            alu_valid = 1'b0;
    logic            ls_drop = 1'b0;
    logic            alu_wb_ready;
    logic            sgpr_we;
    logic [SA-1:0]   sgpr_waddr;
    logic [31:0]     sgpr_wdata;
    logic [WF-1:0]   sgpr_wf;
    logic [T-1:0]    vgpr_we;
    logic [VA-1:0]   vgpr_waddr;
    logic [T*32-1:0] vgpr_wdata;
    logic [WF-1:0]   vgpr_wf;
    logic [CW-1:0]   ls_fifo_count;
    logic            ls_fifo_overflow;
    logic            wb_busy;

    int    checks = 0;
    int    errors = 0;
    int    writes_seen = 0;
    beat_t exp_q[$];

    always #5 clk = ~clk;

    simd32_wb #(.LS_FIFO_DEPTH(DEPTH)) dut (
        .clk                  (clk),
        .reset                (reset),
        .ls_wb_s_dest_reg     (ls_e.s_reg),
        .ls_wb_s_val          (ls_e.s_val),
        .ls_wb_s_strb         (ls_e.s_strb),
        .ls_wb_s_we           (ls_e.s_we),
        .ls_wb_v_dest_reg     (ls_e.v_reg),
        .ls_wb_v_val          (ls_e.v_val),
        .ls_wb_v_strb         (ls_e.v_strb),
        .ls_wb_v_we           (ls_e.v_we),
        .ls_wb_wavefront_num  (ls_e.wf),
        .alu_wb_valid         (alu_valid),
        .alu_wb_ready         (alu_wb_ready),
        .alu_wb_s_dest_reg    (alu_e.s_reg),
        .alu_wb_s_val         (alu_e.s_val),
        .alu_wb_s_strb        (alu_e.s_strb),
        .alu_wb_s_we          (alu_e.s_we),
        .alu_wb_v_dest_reg    (alu_e.v_reg),
        .alu_wb_v_val         (alu_e.v_val),
        .alu_wb_v_strb        (alu_e.v_strb),
        .alu_wb_v_we          (alu_e.v_we),
        .alu_wb_wavefront_num (alu_e.wf),
        .sgpr_we              (sgpr_we),
        .sgpr_waddr           (sgpr_waddr),
        .sgpr_wdata           (sgpr_wdata),
        .sgpr_wf              (sgpr_wf),
        .vgpr_we              (vgpr_we),
        .vgpr_waddr           (vgpr_waddr),
        .vgpr_wdata           (vgpr_wdata),
        .vgpr_wf              (vgpr_wf),
        .ls_fifo_count        (ls_fifo_count),
        .ls_fifo_overflow     (ls_fifo_overflow),
        .wb_busy              (wb_busy)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic ent_t mk_ent(input logic [SA-1:0] sr, input logic [63:0] sv,
                                    input logic [1:0] ss, input logic swe,
                                    input logic [VA-1:0] vr, input logic [63:0] vbase,
                                    input logic [1:0] vs, input logic [T-1:0] vwe,
                                    input logic [WF-1:0] wf);
        ent_t e;
        e.s_reg  = sr;
        e.s_val  = sv;
        e.s_strb = ss;
        e.s_we   = swe;
        e.v_reg  = vr;
        e.v_strb = vs;
        e.v_we   = vwe;
        e.wf     = wf;
        for (int i = 0; i < T; i++) e.v_val[i*64 +: 64] = vbase ^ {32'(i * 3), 32'(i * 7)};
        return e;
    endfunction

    function automatic logic ent_live(input ent_t e);
        return (e.s_we && e.s_strb != 2'b00) || (e.v_we != '0 && e.v_strb != 2'b00);
    endfunction

    // Expected beats of one entry, in issue order.
    task automatic push_beats(input ent_t e);
        beat_t b;
        logic  s_on;
        logic  v_on;
        for (int k = 0; k < 2; k++) begin
            s_on = e.s_we && e.s_strb[k];
            v_on = (e.v_we != '0) && e.v_strb[k];
            if (s_on || v_on) begin
                b.s_we   = s_on;
                b.s_addr = e.s_reg + SA'(k);
                b.s_data = (k == 1) ? e.s_val[63:32] : e.s_val[31:0];
                b.v_we   = e.v_strb[k] ? e.v_we : '0;
                b.v_addr = e.v_reg + VA'(k);
                for (int i = 0; i < T; i++)
                    b.v_data[i*32 +: 32] = (k == 1) ? e.v_val[i*64 + 32 +: 32] : e.v_val[i*64 +: 32];
                b.wf = e.wf;
                exp_q.push_back(b);
            end
        end
    endtask

    // Record expectations at the edge where the DUT takes an entry: ALU accept
    // first, since a same-edge load/store push lands in the FIFO behind it.
    always @(posedge clk) begin
        if (reset) exp_q.delete();
        else begin
            if (alu_valid && alu_wb_ready) push_beats(alu_e);
            if (ent_live(ls_e) && !ls_drop) push_beats(ls_e);
        end
    end

    // Compare every observed write against the head of the scoreboard.
    always @(negedge clk) begin : mon
        beat_t b;
        int    idx;
        if (!reset && (sgpr_we || vgpr_we != '0)) begin
            writes_seen++;
            chk("sb_has_expect", 64'(exp_q.size() != 0), 64'(1));
            if (exp_q.size() != 0) begin
                b = exp_q.pop_front();
                chk("sgpr_we", 64'(sgpr_we), 64'(b.s_we));
                if (b.s_we) begin
                    chk("sgpr_waddr", 64'(sgpr_waddr), 64'(b.s_addr));
                    chk("sgpr_wdata", 64'(sgpr_wdata), 64'(b.s_data));
                    chk("sgpr_wf", 64'(sgpr_wf), 64'(b.wf));
                end
                chk("vgpr_we", 64'(vgpr_we), 64'(b.v_we));
                if (b.v_we != '0) begin
                    idx = 0;
                    for (int i = T - 1; i >= 0; i--)
                        if (vgpr_wdata[i*32 +: 32] !== b.v_data[i*32 +: 32]) idx = i;
                    chk("vgpr_waddr", 64'(vgpr_waddr), 64'(b.v_addr));
                    chk("vgpr_wdata_lane", 64'(vgpr_wdata[idx*32 +: 32]), 64'(b.v_data[idx*32 +: 32]));
                    chk("vgpr_wf", 64'(vgpr_wf), 64'(b.wf));
                end
            end
        end
    end

    task automatic drain(input string tag);
        int n;
        n = 0;
        while ((wb_busy || exp_q.size() != 0) && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_drain_in_time"}, 64'(n < 60), 64'(1));
        @(posedge clk);
        #1;
    endtask

    task automatic alu_send(input ent_t e);
        int n;
        bit got;
        n = 0;
        got = 0;
        alu_e = e;
        alu_valid = 1'b1;
        while (!got && n < 20) begin
            @(negedge clk);
            if (alu_wb_ready) got = 1;
            n++;
        end
        chk("alu_accept_in_time", 64'(got), 64'(1));
        @(posedge clk);
        #1;
        alu_valid = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int wr0;
        int stall;
        bit got;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_sgpr_we", 64'(sgpr_we), 64'(0));
        chk("rst_sgpr_waddr", 64'(sgpr_waddr), 64'(0));
        chk("rst_sgpr_wdata", 64'(sgpr_wdata), 64'(0));
        chk("rst_vgpr_we", 64'(vgpr_we), 64'(0));
        chk("rst_vgpr_wdata_zero", 64'(vgpr_wdata != '0), 64'(0));
        chk("rst_count", 64'(ls_fifo_count), 64'(0));
        chk("rst_overflow", 64'(ls_fifo_overflow), 64'(0));
        chk("rst_busy", 64'(wb_busy), 64'(0));
        chk("rst_ready_low", 64'(alu_wb_ready), 64'(0));
        @(posedge clk);
        #1 reset = 1'b0;

        // ALU single-beat scalar
        alu_e = mk_ent(SA'(5), 64'h12345678_DEADBEEF, 2'b01, 1'b1, '0, '0, 2'b00, '0, WF'(3));
        alu_valid = 1'b1;
        @(negedge clk);
        chk("alu1_ready", 64'(alu_wb_ready), 64'(1));
        @(posedge clk);
        #1 alu_valid = 1'b0;
        @(negedge clk);
        chk("alu1_n1_we", 64'(sgpr_we), 64'(1));
        chk("alu1_n1_waddr", 64'(sgpr_waddr), 64'(5));
        chk("alu1_n1_wdata", 64'(sgpr_wdata), 64'h0000_0000_DEAD_BEEF);
        @(negedge clk);
        chk("alu1_n2_no_write", 64'(sgpr_we), 64'(0));
        drain("alu1");

        // Load/store double-beat vector
        ls_e = mk_ent('0, '0, 2'b00, 1'b0, VA'(10), 64'h11111111_22222222, 2'b11, 32'h0000FFFF, WF'(5));
        @(posedge clk);
        #1 ls_e = '0;
        @(negedge clk);
        chk("lsv_n1_no_write", 64'(vgpr_we), 64'(0));
        chk("lsv_n1_count", 64'(ls_fifo_count), 64'(1));
        @(negedge clk);
        chk("lsv_n2_we", 64'(vgpr_we), 64'h0000FFFF);
        chk("lsv_n2_waddr", 64'(vgpr_waddr), 64'(10));
        chk("lsv_n2_lane0", 64'(vgpr_wdata[31:0]), 64'h22222222);
        @(negedge clk);
        chk("lsv_n3_waddr", 64'(vgpr_waddr), 64'(11));
        chk("lsv_n3_lane0", 64'(vgpr_wdata[31:0]), 64'h11111111);
        drain("lsv");

        // Priority: load/store entry ahead of a waiting ALU entry
        ls_e = mk_ent(SA'(20), 64'hAAAA0001_BBBB0002, 2'b11, 1'b1, '0, '0, 2'b00, '0, WF'(1));
        @(posedge clk);
        #1 ls_e = '0;
        alu_e = mk_ent(SA'(30), 64'h0_00000C30, 2'b01, 1'b1, VA'(31), 64'h5555_6666_7777_8888, 2'b01, '1, WF'(2));
        alu_valid = 1'b1;
        stall = 0;
        got = 0;
        repeat (10) begin
            if (!got) begin
                @(negedge clk);
                if (alu_wb_ready) got = 1;
                else stall++;
            end
        end
        chk("prio_accepted", 64'(got), 64'(1));
        chk("prio_stall_cycles", 64'(stall), 64'(2));
        @(posedge clk);
        #1 alu_valid = 1'b0;
        drain("prio");

        // Overflow: double-beat pushes every cycle until one is dropped
        wr0 = writes_seen;
        for (int i = 0; i < 9; i++) begin
            ls_e = mk_ent(SA'(40 + 2 * i), {32'h0F00_0000 + 32'(i), 32'hF000_0000 + 32'(i)}, 2'b11, 1'b1,
                          VA'(100 + 2 * i), {32'(i), 32'h00C0_0000}, 2'b11, 32'(1) << i, WF'(i));
            ls_drop = (i == 8);
            if (i == 8) begin
                @(negedge clk);
                chk("ovf_full_count", 64'(ls_fifo_count), 64'(DEPTH));
                chk("ovf_not_yet", 64'(ls_fifo_overflow), 64'(0));
            end
            @(posedge clk);
            #1;
        end
        ls_e = '0;
        ls_drop = 1'b0;
        @(negedge clk);
        chk("ovf_set", 64'(ls_fifo_overflow), 64'(1));
        chk("ovf_count_after_drop", 64'(ls_fifo_count), 64'(DEPTH));
        drain("ovf");
        chk("ovf_beats_written", 64'(writes_seen - wr0), 64'(16));
        chk("ovf_sticky", 64'(ls_fifo_overflow), 64'(1));

        // Address wrap on both ports, then a high-beat-only entry
        alu_send(mk_ent(SA'((1 << SA) - 1), 64'hCAFEF00D_0BADF00D, 2'b11, 1'b1,
                        VA'((1 << VA) - 1), 64'h0123_4567_89AB_CDEF, 2'b11, '1, WF'(7)));
        @(negedge clk);
        chk("wrap_b0_addr", 64'(sgpr_waddr), 64'((1 << SA) - 1));
        @(negedge clk);
        chk("wrap_b1_addr", 64'(sgpr_waddr), 64'(0));
        chk("wrap_b1_data", 64'(sgpr_wdata), 64'hCAFEF00D);
        chk("wrap_v_b1_addr", 64'(vgpr_waddr), 64'(0));
        drain("wrap");
        wr0 = writes_seen;
        ls_e = mk_ent(SA'(50), 64'hA5A5A5A5_5A5A5A5A, 2'b10, 1'b1, '0, '0, 2'b00, '0, WF'(9));
        @(posedge clk);
        #1 ls_e = '0;
        drain("strb10");
        chk("strb10_one_write", 64'(writes_seen - wr0), 64'(1));
        chk("strb10_addr", 64'(sgpr_waddr), 64'(51));
        chk("strb10_data", 64'(sgpr_wdata), 64'hA5A5A5A5);

        // Reset mid-operation: WB_HI with two entries queued
        for (int i = 0; i < 4; i++) begin
            ls_e = mk_ent(SA'(70 + 2 * i), {32'h7000_0000 + 32'(i), 32'h0700_0000 + 32'(i)}, 2'b11, 1'b1,
                          '0, '0, 2'b00, '0, WF'(i));
            @(posedge clk);
            #1;
        end
        ls_e = '0;
        reset = 1'b1;
        alu_e = mk_ent(SA'(60), 64'h0_00006060, 2'b01, 1'b1, '0, '0, 2'b00, '0, WF'(4));
        alu_valid = 1'b1;
        @(negedge clk);
        chk("mid_pre_count", 64'(ls_fifo_count), 64'(2));
        chk("mid_pre_busy", 64'(wb_busy), 64'(1));
        chk("mid_ready_in_reset", 64'(alu_wb_ready), 64'(0));
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("mid_sgpr_we", 64'(sgpr_we), 64'(0));
        chk("mid_sgpr_waddr", 64'(sgpr_waddr), 64'(0));
        chk("mid_sgpr_wdata", 64'(sgpr_wdata), 64'(0));
        chk("mid_sgpr_wf", 64'(sgpr_wf), 64'(0));
        chk("mid_count", 64'(ls_fifo_count), 64'(0));
        chk("mid_overflow_cleared", 64'(ls_fifo_overflow), 64'(0));
        chk("mid_busy", 64'(wb_busy), 64'(0));
        chk("mid_ready_still_low", 64'(alu_wb_ready), 64'(0));
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("mid_ready_after", 64'(alu_wb_ready), 64'(1));
        @(posedge clk);
        #1 alu_valid = 1'b0;
        drain("mid");

        chk("sb_empty_end", 64'(exp_q.size()), 64'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
